// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM encoding, byte width and default bit timing.
package uart_pkg;

    // Byte width carried by the feeder, FIFO and uart_tx/uart_rx.
    localparam int unsigned BYTE_W = 8;

    // 10 MHz system clock, 115200 baud.
    localparam int unsigned CLKS_PER_BIT = 87;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACT  = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with registered full/empty/count flags and an overflow pulse.
// Data storage is not reset; only pointers and flags are.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   count_next,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q, overflow_q;
    logic              push_ok, pop_ok;

    // Acceptance is judged on the registered flags, so a pop in the same
    // cycle cannot rescue a write that arrives while full.
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    // Occupancy next state: push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and flag registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_FULL);
            empty_q    <= (count_d == '0);
            overflow_q <= push && full_q;
        end
    end

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    assign head       = mem[rd_ptr_q];
    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign count_next = count_d;
    assign overflow   = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and launch sequencer in front of uart_tx. Bytes are queued in a
// sync_fifo and launched one per frame, paced on uart_tx's active/done signals.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_DV,
    input  logic [BYTE_W-1:0] i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Tx_DV,
    output logic [BYTE_W-1:0] o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Busy
);

    feeder_state_t     state_q, state_d;
    logic              tx_dv_q, tx_dv_d;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic              pop;
    logic [BYTE_W-1:0] fifo_head;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_count_next;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (i_Clock),
        .rst        (i_Reset),
        .push       (i_Wr_DV),
        .push_data  (i_Wr_Byte),
        .pop        (pop),
        .head       (fifo_head),
        .full       (o_Full),
        .empty      (fifo_empty),
        .count      (o_Count),
        .count_next (fifo_count_next),
        .overflow   (o_Overflow)
    );

    // Launch sequencing; the idle guard on i_Tx_Active also covers a frame
    // still running in uart_tx after a feeder reset.
    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !i_Tx_Active) begin
                    pop       = 1'b1;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = fifo_head;
                    state_d   = S_WAIT_ACT;
                end
            end
            S_WAIT_ACT: begin
                if (i_Tx_Done)        state_d = S_GAP;
                else if (i_Tx_Active) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) || (fifo_count_next != '0);
    end

    // FSM and output registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            busy_q    <= busy_d;
        end
    end

    assign o_Empty   = fifo_empty;
    assign o_Tx_DV   = tx_dv_q;
    assign o_Tx_Byte = tx_byte_q;
    assign o_Busy    = busy_q;

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte buffer and launch sequencer directly upstream of uart_tx.
- Producer logic pushes bytes at clock rate into an internal FIFO.
- The feeder hands bytes one at a time to uart_tx via its i_Tx_DV / i_Tx_Byte strobe.
- It paces launches on uart_tx's o_Tx_Active / o_Tx_Done, so back-to-back bytes leave the serial line with no lost or overlapped frames.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- i_Clock  in  1  system clock; the only clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Wr_DV  in  1  one-cycle write strobe from producer.
- i_Wr_Byte  in  8  byte written when i_Wr_DV=1.
- o_Full  out  1  FIFO holds DEPTH bytes.
- o_Empty  out  1  FIFO holds 0 bytes.
- o_Count  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- o_Overflow  out  1  one-cycle pulse when a write is dropped.
- o_Tx_DV  out  1  launch strobe to uart_tx i_Tx_DV.
- o_Tx_Byte  out  8  byte to uart_tx i_Tx_Byte; held until the next launch.
- i_Tx_Active  in  1  from uart_tx o_Tx_Active.
- i_Tx_Done  in  1  from uart_tx o_Tx_Done (one-cycle pulse).
- o_Busy  out  1  FSM is not in S_IDLE, or FIFO is not empty.

Behaviour:
- Reset values:
  - Pointers and count = 0.
  - o_Empty=1, o_Full=0, o_Overflow=0, o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0.
  - FSM = S_IDLE.
  - FIFO contents are not reset.
- All outputs are registered.
- Write acceptance:
  - Accepted when i_Wr_DV=1 and o_Full=0, judged on the registered flag.
  - Write while o_Full=1 is dropped and o_Overflow pulses 1 cycle, even if a pop occurs in the same cycle.
- Pointers are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
- o_Count update per cycle: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Simultaneous push and pop with count=1: the popped byte is the old head; the new byte remains; count stays 1.
- FSM states:
  - S_IDLE: if o_Empty=0 and i_Tx_Active=0, pop the head, load o_Tx_Byte, set o_Tx_DV=1 for exactly 1 cycle, go to S_WAIT_ACT.
  - S_WAIT_ACT: wait for i_Tx_Active=1, then go to S_WAIT_DONE. If i_Tx_Done=1 arrives first, go to S_GAP.
  - S_WAIT_DONE: on i_Tx_Done=1, go to S_GAP.
  - S_GAP: one cycle, then S_IDLE. This guarantees uart_tx has returned to idle before the next strobe.
- Latency: a write accepted at edge N into an empty, idle feeder gives o_Tx_DV=1 in the cycle following edge N+1.
- Throughput: one byte per uart_tx frame plus 2 cycles of gap.
- Reset mid-frame:
  - FIFO is flushed and the FSM returns to S_IDLE.
  - uart_tx has no reset, so its current frame completes.
  - The S_IDLE guard (i_Tx_Active=0) blocks any new launch until that frame ends.
- No timeout; i_Tx_Done is always expected.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings: S_IDLE=2'd0, S_WAIT_ACT=2'd1, S_WAIT_DONE=2'd2, S_GAP=2'd3.
  - Default CLKS_PER_BIT=87 (10 MHz, 115200 baud), for shared use with uart_tx and uart_rx.
- One sub-module: sync_fifo.
  - Parameters DEPTH and ADDR_W; 8-bit data.
  - Provides push, pop, full, empty, count and overflow.
  - Reused later for the uart_rx side.
- The feeder top holds the FSM only.

Test Plan (10 MHz clock, feeder connected to uart_tx with CLKS_PER_BIT=87, uart_rx looping the serial line back):
- Single byte: push 8'hAB -> o_Tx_DV high in exactly 1 cycle, 2 edges after the push; uart_rx delivers 8'hAB; o_Busy returns to 0 after i_Tx_Done plus 1 cycle.
- Burst: push 8'h3F, 8'h55, 8'hA0, 8'hFF in consecutive cycles -> o_Count peaks at 3 or 4; uart_rx receives all 4 in order; exactly 4 o_Tx_DV pulses; none occur while i_Tx_Active=1.
- Overflow: with the FSM in S_WAIT_DONE, push 17 bytes at DEPTH=16 -> o_Full=1 after 16 bytes; the 17th is dropped with o_Overflow pulsing 1 cycle; the 16 stored bytes are received intact.
- Wrap-around: push/pop a total of 40 bytes 8'h00..8'h27 while keeping occupancy at or below 5 -> pointers wrap twice; bytes are received in order with no corruption.
- Simultaneous push and pop at count=1 -> count stays 1; the popped byte is the old head.
- Reset mid-frame: assert i_Reset for 1 cycle during the data bits of 8'hC3 with 3 bytes queued -> o_Count=0, o_Empty=1; the 8'hC3 frame completes on the line; no o_Tx_DV until i_Tx_Active=0; a new push of 8'h5A is then received correctly.
